// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (EX) and the address generator (AG).
// Round-robin grant, a three-state sequence per operation (IDLE, EXEC, RESP), a registered
// result on a valid/ready response channel, and the architectural Z/N/V flag register.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    // EX request channel
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [OPW-1:0]   ex_opcode,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    input  logic [3:0]       ex_imm,
    // AG request channel
    input  logic             ag_valid,
    output logic             ag_ready,
    input  logic             ag_is_store,
    input  logic [WIDTH-1:0] ag_base,
    input  logic [WIDTH-1:0] ag_offset,
    // Shared ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_imm,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    // Response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    // Architectural flags
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    // Which flags an operation commits when it leaves EXEC.
    typedef enum logic [1:0] {FlagNone, FlagZ, FlagZnv} flag_sel_t;

    localparam logic GrantEx = 1'b0;
    localparam logic GrantAg = 1'b1;

    localparam logic [OPW-1:0] OpAdd = OPW'(4'b0000);
    localparam logic [OPW-1:0] OpSub = OPW'(4'b0001);
    localparam logic [OPW-1:0] OpAnd = OPW'(4'b0010);
    localparam logic [OPW-1:0] OpOr  = OPW'(4'b0011);
    localparam logic [OPW-1:0] OpXor = OPW'(4'b0100);
    localparam logic [OPW-1:0] OpOp5 = OPW'(4'b0101);
    localparam logic [OPW-1:0] OpOp7 = OPW'(4'b0111);
    localparam logic [OPW-1:0] OpLw  = OPW'(4'b1000);
    localparam logic [OPW-1:0] OpSw  = OPW'(4'b1001);

    state_t           state;
    logic             last_grant;
    logic [OPW-1:0]   op_opcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       op_imm;
    logic             op_id;
    flag_sel_t        op_flag_sel;

    logic      grant_ex;
    logic      grant_ag;
    logic      ex_supported;
    flag_sel_t ex_flag_sel;

    // Round-robin grant from the current valids; only IDLE exposes ready.
    always_comb begin
        grant_ex = ex_valid && (!ag_valid || (last_grant == GrantAg));
        grant_ag = ag_valid && (!ex_valid || (last_grant == GrantEx));
        ex_ready = (state == StIdle) && grant_ex;
        ag_ready = (state == StIdle) && grant_ag;
    end

    // Decode the EX opcode: is it legal for the ALU, and which flags it commits.
    always_comb begin
        ex_supported = 1'b0;
        ex_flag_sel  = FlagNone;
        case (ex_opcode)
            OpAdd, OpSub: begin
                ex_supported = 1'b1;
                ex_flag_sel  = FlagZnv;
            end
            OpAnd, OpXor, OpOp5: begin
                ex_supported = 1'b1;
                ex_flag_sel  = FlagZ;
            end
            OpOr, OpOp7: begin
                ex_supported = 1'b1;
                ex_flag_sel  = FlagNone;
            end
            default: begin
                ex_supported = 1'b0;
                ex_flag_sel  = FlagNone;
            end
        endcase
    end

    // The ALU only sees the latched operands while in EXEC; otherwise it idles on 0000/0/0.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_imm    = '0;
        alu_opcode = '0;
        if (state == StExec) begin
            alu_a      = op_a;
            alu_b      = op_b;
            alu_imm    = op_imm;
            alu_opcode = op_opcode;
        end
    end

    // Operation sequencer: accept, execute, hold the response until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            last_grant  <= GrantAg;
            op_opcode   <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_imm      <= '0;
            op_id       <= 1'b0;
            op_flag_sel <= FlagNone;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_v      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (ex_ready) begin
                        // Unsupported opcodes run as a harmless 0000/0/0 with no flag commit.
                        op_opcode   <= ex_supported ? ex_opcode : OpAdd;
                        op_a        <= ex_supported ? ex_a : '0;
                        op_b        <= ex_supported ? ex_b : '0;
                        op_imm      <= ex_supported ? ex_imm : 4'd0;
                        op_flag_sel <= ex_flag_sel;
                        op_id       <= GrantEx;
                        last_grant  <= GrantEx;
                        state       <= StExec;
                    end else if (ag_ready) begin
                        op_opcode   <= ag_is_store ? OpSw : OpLw;
                        op_a        <= ag_base;
                        op_b        <= ag_offset;
                        op_imm      <= 4'd0;
                        op_flag_sel <= FlagNone;
                        op_id       <= GrantAg;
                        last_grant  <= GrantAg;
                        state       <= StExec;
                    end
                end
                StExec: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= op_id;
                    rsp_data  <= alu_out;
                    if (op_flag_sel != FlagNone) begin
                        flag_z <= alu_z;
                    end
                    if (op_flag_sel == FlagZnv) begin
                        flag_n <= alu_n;
                        flag_v <= alu_v;
                    end
                    state <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_a, ex_b;
    logic [3:0]  ex_imm;
    logic        ag_valid, ag_ready, ag_is_store;
    logic [15:0] ag_base, ag_offset;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_imm, alu_opcode;
    logic        alu_z, alu_n, alu_v;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;
    logic        flag_z, flag_n, flag_v;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    alu_share_arbiter #(.WIDTH(16), .OPW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_opcode  (ex_opcode),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_imm     (ex_imm),
        .ag_valid   (ag_valid),
        .ag_ready   (ag_ready),
        .ag_is_store(ag_is_store),
        .ag_base    (ag_base),
        .ag_offset  (ag_offset),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_imm    (alu_imm),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_v      (alu_v),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 7 SLL, 8/9 address add.
    always_comb begin
        alu_out = '0;
        alu_v   = 1'b0;
        case (alu_opcode)
            4'b0000: begin
                alu_out = alu_a + alu_b;
                alu_v   = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
            end
            4'b0001: begin
                alu_out = alu_a - alu_b;
                alu_v   = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
            end
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = ~(alu_a & alu_b);
            4'b0111: alu_out = alu_a << alu_imm;
            4'b1000, 4'b1001: alu_out = {alu_a[15:1], 1'b0} + alu_b;
            default: alu_out = '0;
        endcase
        alu_z = (alu_out == 16'd0);
        alu_n = alu_out[15];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s: timed out waiting, observed no event expected one", tag);
    endtask

    // Compare the response currently presented against the oldest expectation.
    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed unexpected response %h expected none", tag, rsp_data);
        end else begin
            e = sb.pop_front();
            check({tag, "_id"}, 32'(rsp_id), 32'(e.id));
            check({tag, "_data"}, 32'(rsp_data), 32'(e.data));
        end
    endtask

    // Drive an EX request until accepted; returns just after the accept edge (in EXEC).
    task automatic send_ex(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] imm, input logic [15:0] exp_data);
        int w = 0;
        @(negedge clk);
        ex_valid  = 1'b1;
        ex_opcode = op;
        ex_a      = a;
        ex_b      = b;
        ex_imm    = imm;
        #1;
        while (!ex_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!ex_ready) timeout("ex_accept");
        acc_cyc = cyc;
        sb.push_back('{id: 1'b0, data: exp_data});
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic send_ag(input logic st, input logic [15:0] base, input logic [15:0] off,
                           input logic [15:0] exp_data);
        int w = 0;
        @(negedge clk);
        ag_valid    = 1'b1;
        ag_is_store = st;
        ag_base     = base;
        ag_offset   = off;
        #1;
        while (!ag_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!ag_ready) timeout("ag_accept");
        acc_cyc = cyc;
        sb.push_back('{id: 1'b1, data: exp_data});
        @(posedge clk);
        #1;
        ag_valid = 1'b0;
    endtask

    // Wait for the response (rsp_ready assumed high), check it and its latency.
    task automatic get_rsp(input string tag);
        int w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!rsp_valid) begin
            timeout({tag, "_rsp"});
        end else begin
            check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd2);
            pop_check(tag);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: simulation observed no end expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit gid[4];
        int gcyc[4];
        int n;

        rst = 1'b1;
        ex_valid = 1'b0; ex_opcode = '0; ex_a = '0; ex_b = '0; ex_imm = '0;
        ag_valid = 1'b0; ag_is_store = 1'b0; ag_base = '0; ag_offset = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_flags", 32'({flag_z, flag_n, flag_v}), 0);
        check("rst_alu_opcode", 32'(alu_opcode), 0);
        check("rst_ready", 32'({ex_ready, ag_ready}), 0);
        rsp_ready = 1'b1;

        // ADD with signed overflow
        send_ex(4'b0000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000);
        check("add_alu_opcode", 32'(alu_opcode), 32'h0);
        check("add_alu_a", 32'(alu_a), 32'h7FFF);
        get_rsp("add");
        check("add_flags", 32'({flag_z, flag_n, flag_v}), 32'b011);

        // XOR commits Z only
        send_ex(4'b0100, 16'h00F0, 16'h00F0, 4'd0, 16'h0000);
        get_rsp("xor");
        check("xor_flags", 32'({flag_z, flag_n, flag_v}), 32'b111);

        // LW address: LSB of base cleared by the ALU, flags untouched
        send_ag(1'b0, 16'h1001, 16'h0004, 16'h1004);
        check("lw_alu_opcode", 32'(alu_opcode), 32'b1000);
        check("lw_alu_b", 32'(alu_b), 32'h0004);
        get_rsp("lw");
        check("lw_flags", 32'({flag_z, flag_n, flag_v}), 32'b111);

        // SW opcode mapping
        send_ag(1'b1, 16'h0200, 16'h0010, 16'h0210);
        check("sw_alu_opcode", 32'(alu_opcode), 32'b1001);
        get_rsp("sw");

        // Unsupported opcode runs as 0000/0/0 without a flag commit
        send_ex(4'b1100, 16'h1234, 16'h4321, 4'd3, 16'h0000);
        check("unsup_alu_opcode", 32'(alu_opcode), 0);
        check("unsup_alu_a", 32'(alu_a), 0);
        get_rsp("unsup");
        check("unsup_flags", 32'({flag_z, flag_n, flag_v}), 32'b111);

        // Back-pressure: response held for 5 cycles while EX waits
        rsp_ready = 1'b0;
        send_ex(4'b0000, 16'h0001, 16'h0002, 4'd0, 16'h0003);
        @(negedge clk);
        @(negedge clk);
        ex_valid = 1'b1; ex_opcode = 4'b0100; ex_a = 16'h0005; ex_b = 16'h0003; ex_imm = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_rsp_valid", 32'(rsp_valid), 1);
            check("stall_rsp_data", 32'(rsp_data), 32'h0003);
            check("stall_ex_ready", 32'(ex_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        pop_check("stall");
        @(negedge clk);
        #1;
        check("stall_ready_after", 32'(ex_ready), 1);
        check("stall_rsp_cleared", 32'(rsp_valid), 0);
        acc_cyc = cyc;
        sb.push_back('{id: 1'b0, data: 16'h0006});
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        get_rsp("post_stall");
        check("post_stall_flags", 32'({flag_z, flag_n, flag_v}), 32'b000);

        // Fairness: both requesters valid from reset
        @(negedge clk);
        rst = 1'b1;
        ex_valid = 1'b1; ex_opcode = 4'b0000; ex_a = 16'h0010; ex_b = 16'h0020; ex_imm = '0;
        ag_valid = 1'b1; ag_is_store = 1'b0; ag_base = 16'h2000; ag_offset = 16'h0002;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int t = 0; t < 60 && !(n == 4 && sb.size() == 0); t++) begin
            #1;
            check("fair_one_ready", 32'(ex_ready && ag_ready), 0);
            if (rsp_valid) pop_check("fair");
            if ((ex_ready || ag_ready) && n < 4) begin
                gid[n]  = ag_ready;
                gcyc[n] = cyc;
                sb.push_back('{id: ag_ready, data: ag_ready ? 16'h2002 : 16'h0030});
                n++;
            end
            @(posedge clk);
            #1;
            if (n == 4) begin
                ex_valid = 1'b0;
                ag_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("fair_grants", 32'(n), 4);
        if (n == 4) begin
            check("fair_order", 32'({gid[0], gid[1], gid[2], gid[3]}), 32'b0101);
            for (int i = 1; i < 4; i++) check("fair_spacing", 32'(gcyc[i] - gcyc[i-1]), 3);
        end
        check("fair_drained", 32'(sb.size()), 0);

        // Reset during EXEC aborts the operation and restores EX priority
        @(negedge clk);
        ex_valid = 1'b1; ex_opcode = 4'b0000; ex_a = 16'h7FFF; ex_b = 16'h0001; ex_imm = '0;
        #1;
        check("abort_accept", 32'(ex_ready), 1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        check("abort_rsp_data", 32'(rsp_data), 0);
        check("abort_flags", 32'({flag_z, flag_n, flag_v}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_rsp", 32'(rsp_valid), 0);
        end
        ex_valid = 1'b1;
        ag_valid = 1'b1;
        #1;
        check("abort_tie", 32'({ex_ready, ag_ready}), 32'b10);
        ex_valid = 1'b0;
        ag_valid = 1'b0;
        #1;
        check("abort_sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance between two requesters: the execute stage (EX) and the memory address generator (AG, for LW/SW).
- Arbitrates round-robin and sequences each operation through a 3-state FSM.
- Registers the ALU result and returns it over a valid/ready response channel.
- Owns the architectural Z/N/V flag register, updated only by committed EX operations.
- Sits between the decode/execute control path and the ALU; the ALU itself is unchanged.

Parameters:
- WIDTH, 16, datapath width of operands and result.
- OPW, 4, opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- ex_valid  input  1  EX request valid.
- ex_ready  output  1  EX request accepted this cycle when ex_valid is also high.
- ex_opcode  input  OPW  ALU opcode for the EX request.
- ex_a  input  WIDTH  EX operand A.
- ex_b  input  WIDTH  EX operand B.
- ex_imm  input  4  EX shift amount.
- ag_valid  input  1  AG request valid.
- ag_ready  output  1  AG request accepted this cycle when ag_valid is also high.
- ag_is_store  input  1  1=SW, 0=LW.
- ag_base  input  WIDTH  base register value.
- ag_offset  input  WIDTH  sign-extended, shifted offset.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_imm  output  4  to ALU imm.
- alu_opcode  output  OPW  to ALU Opcode.
- alu_out  input  WIDTH  from ALU ALU_Out.
- alu_z  input  1  ALU Z flag.
- alu_n  input  1  ALU N flag.
- alu_v  input  1  ALU V flag.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  0=EX, 1=AG.
- rsp_data  output  WIDTH  registered result.
- flag_z  output  1  architectural Z flag.
- flag_n  output  1  architectural N flag.
- flag_v  output  1  architectural V flag.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE; rsp_valid=0; rsp_id=0; rsp_data=0.
  - flag_z/n/v=0.
  - last_grant=AG, so EX wins the first tie.
  - Operand registers=0.
- Reset asserted mid-operation aborts the operation: no response and no flag update.
- FSM states and transitions:
  - IDLE -> EXEC on an accept.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE on rsp_ready.
- Ready and grant:
  - ex_ready and ag_ready may be high only in IDLE, and never both in the same cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not named by last_grant wins.
  - last_grant updates on every accept.
  - The grant is computed from the current valids; ready may depend combinationally on valid.
- Accept (IDLE, valid&ready): latch opcode, A, B, imm and id into operand registers.
  - EX: opcode=ex_opcode, A=ex_a, B=ex_b, imm=ex_imm.
  - AG: opcode=1000 (LW) or 1001 (SW), A=ag_base, B=ag_offset, imm=0. The ALU clears the LSB of A.
- EXEC: alu_* are driven from the operand registers. At the clock edge, latch rsp_data=alu_out and rsp_id, and commit flags.
- In IDLE and RESP, alu_opcode=0000 and alu_a/b/imm=0. The ALU is never presented with an unsupported opcode.
- Supported EX opcodes: 0000, 0001, 0010, 0011, 0100, 0101, 0111.
- Any other ex_opcode is still accepted. The operand register stores 0000/0/0, so rsp_data=0 and flags are not updated.
- Flag commit, at the EXEC->RESP edge, EX requests only:
  - 0000 ADD and 0001 SUB update Z, N and V.
  - 0010, 0100 and 0101 update Z only.
  - All other opcodes and all AG requests leave the flags unchanged.
- RESP: rsp_valid=1, with rsp_id and rsp_data stable until rsp_ready.
- Latency and throughput:
  - Response appears 2 cycles after accept.
  - Minimum initiation interval is 3 cycles. No new accept occurs in the cycle rsp_ready is seen; the next accept is one cycle later.
- Fairness: with both requesters continuously valid, grants alternate EX, AG, EX, AG...
- A requester may drop valid before ready without penalty. No request is held internally.

Test Plan:
- Reset, then EX ADD a=16'h7FFF b=16'h0001 -> rsp_valid 2 cycles after accept; rsp_id=0; rsp_data=16'h8000; flags Z=0 N=1 V=1.
- After the ADD, EX XOR a=16'h00F0 b=16'h00F0 -> rsp_data=0; Z=1; N and V hold 1 and 1. Then AG LW base=16'h1001 offset=16'h0004 -> rsp_id=1; rsp_data=16'h1004; flags unchanged.
- ex_valid and ag_valid held high from reset for 4 operations, rsp_ready=1 -> grant order EX, AG, EX, AG; accepts spaced exactly 3 cycles; never both readies high.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable; ex_ready=0 throughout; accept occurs the cycle after rsp_ready rises.
- EX opcode 4'b1100 -> accepted; alu_opcode stays 0000; rsp_data=0; flags unchanged.
- rst asserted in EXEC -> next cycle state IDLE, rsp_valid=0, flags 0; no response for the aborted op; the next tie goes to EX.
